// File: rtl/adaptive_pkg.sv
// Shared types, default sizes and saturating arithmetic for the adaptive FIR slice.
package adaptive_pkg;

  localparam int NTAPS_DEF    = 16;
  localparam int XW_DEF       = 14;
  localparam int WW_DEF       = 32;
  localparam int MU_SHIFT_DEF = 25;

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    DONE
  } state_t;

  // Clamp a wide signed value into the signed range of the given width.
  function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] value,
                                                   input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

  // Operands are at most 32 bits wide, so the 64-bit sum never wraps before clamping.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int width);
    return sat_trunc(a + b, width);
  endfunction

endpackage

// File: rtl/lms_tap_mac.sv
// Scaled LMS step for one tap: sat((e * x_k) >>> MU_SHIFT); purely combinational, 0 cycles.
// No handshake or backpressure: the output follows the inputs.
module lms_tap_mac
  import adaptive_pkg::*;
#(
  parameter int XW       = XW_DEF,
  parameter int WW       = WW_DEF,
  parameter int MU_SHIFT = MU_SHIFT_DEF
) (
  input  logic signed [WW-1:0] e,
  input  logic signed [XW-1:0] x_k,
  output logic signed [WW-1:0] step
);

  logic signed [WW+XW-1:0] prod;
  logic signed [63:0]      shifted;

  assign prod    = (WW+XW)'(e) * (WW+XW)'(x_k);
  assign shifted = 64'(prod) >>> MU_SHIFT;
  assign step    = WW'(sat_trunc(shifted, WW));

endmodule

// File: rtl/lms_weight_update.sv
// LMS coefficient update, one tap per clock; start to done is NTAPS+1 cycles.
// No backpressure: start outside IDLE is dropped, en low aborts to IDLE keeping written taps.
module lms_weight_update
  import adaptive_pkg::*;
#(
  parameter int NTAPS    = NTAPS_DEF,
  parameter int XW       = XW_DEF,
  parameter int WW       = WW_DEF,
  parameter int MU_SHIFT = MU_SHIFT_DEF
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic                    clr,
  input  logic                    start,
  input  logic signed [WW-1:0]    e,
  input  logic [NTAPS*XW-1:0]     x,
  output logic                    busy,
  output logic                    done,
  output logic [NTAPS*WW-1:0]     weight_out
);

  localparam int IW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NTAPS - 1);

  state_t               state;
  logic [IW-1:0]        idx;
  logic signed [WW-1:0] e_snap;
  logic signed [XW-1:0] x_snap [NTAPS];
  logic signed [WW-1:0] w      [NTAPS];
  logic signed [WW-1:0] step;
  logic signed [WW-1:0] w_next;

  // A single MAC is shared across taps; the tap index selects its operands.
  lms_tap_mac #(
    .XW      (XW),
    .WW      (WW),
    .MU_SHIFT(MU_SHIFT)
  ) u_mac (
    .e   (e_snap),
    .x_k (x_snap[idx]),
    .step(step)
  );

  assign w_next = WW'(sat_add(64'(w[idx]), 64'(step), WW));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      idx    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      e_snap <= '0;
      for (int k = 0; k < NTAPS; k++) begin
        x_snap[k] <= '0;
        w[k]      <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (clr) begin
            for (int k = 0; k < NTAPS; k++) w[k] <= '0;
          end else if (en && start) begin
            e_snap <= e;
            for (int k = 0; k < NTAPS; k++) x_snap[k] <= x[k*XW +: XW];
            idx   <= '0;
            busy  <= 1'b1;
            state <= UPDATE;
          end
        end
        UPDATE: begin
          if (!en) begin
            idx   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            w[idx] <= w_next;
            if (idx == LAST) begin
              idx   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    weight_out = '0;
    for (int k = 0; k < NTAPS; k++) weight_out[k*WW +: WW] = w[k];
  end

endmodule

// File: tb/tb_lms_weight_update.sv
// Directed bench for lms_weight_update: timing, signed steps, saturation, abort, clr and reset.
module tb_lms_weight_update;

  localparam int NT = 16;
  localparam int XB = 14;
  localparam int WB = 32;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic                  en;
  logic                  clr;
  logic                  start;
  logic signed [WB-1:0]  e;
  logic [NT*XB-1:0]      x;
  logic                  busy;
  logic                  done;
  logic [NT*WB-1:0]      weight_out;

  int checks = 0;
  int errors = 0;

  lms_weight_update dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .clr       (clr),
    .start     (start),
    .e         (e),
    .x         (x),
    .busy      (busy),
    .done      (done),
    .weight_out(weight_out)
  );

  always #5 clk = ~clk;

  function automatic logic signed [WB-1:0] wk(input int k);
    return weight_out[k*WB +: WB];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    en  = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Full update from IDLE, ending back in IDLE.
  task automatic run_update(input logic signed [WB-1:0] ev, input logic [NT*XB-1:0] xv);
    e     = ev;
    x     = xv;
    en    = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (NT + 2) tick();
  endtask

  // Writes only tap 0, then aborts with en low: three cycles per step.
  task automatic fast_step(input logic signed [WB-1:0] ev, input logic [XB-1:0] x0v);
    e       = ev;
    x       = '0;
    x[XB-1:0] = x0v;
    en      = 1'b1;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    tick();
    en      = 1'b0;
    tick();
    en      = 1'b1;
  endtask

  task automatic test_reset();
    rstn  = 1'b0;
    en    = 1'b0;
    clr   = 1'b0;
    start = 1'b0;
    e     = '0;
    x     = '0;
    repeat (3) tick();
    checks++;
    if (weight_out !== '0) begin
      errors++;
      $display("FAIL reset_weights got %h want 0", weight_out);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got busy=%b done=%b want 0 0", busy, done);
    end
    rstn = 1'b1;
    tick();
    e     = 32'sd33554432;
    x     = '1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_en_low_busy got %b want 0", busy);
    end
    repeat (NT + 2) tick();
    checks++;
    if (weight_out !== '0) begin
      errors++;
      $display("FAIL start_en_low_weights got %h want 0", weight_out);
    end
  endtask

  task automatic test_single_update();
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_at  = -1;
    e = 32'sd33554432;
    for (int k = 0; k < NT; k++) x[k*XB +: XB] = XB'(k);
    en    = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    e     = '0;
    x     = '1;
    for (int i = 0; i <= NT + 2; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_at = i;
      end
      start = (i == NT);
      if (i == NT) e = 32'sd33554432;
      tick();
    end
    start = 1'b0;
    checks++;
    if (busy_cnt !== NT) begin
      errors++;
      $display("FAIL single_busy_cycles got %0d want %0d", busy_cnt, NT);
    end
    checks++;
    if (done_cnt !== 1 || done_at !== NT) begin
      errors++;
      $display("FAIL single_done_pulse got count=%0d at=%0d want 1 at %0d", done_cnt, done_at, NT);
    end
    for (int k = 0; k < NT; k++) begin
      checks++;
      if (wk(k) !== 32'(k)) begin
        errors++;
        $display("FAIL single_w%0d got %0d want %0d", k, wk(k), k);
      end
    end
  endtask

  task automatic test_negative_step();
    logic [NT*XB-1:0] xv;
    xv = '0;
    xv[3*XB +: XB] = 14'sd5;
    run_update(-32'sd67108864, xv);
    for (int k = 0; k < NT; k++) begin
      checks++;
      if (k == 3) begin
        if (wk(k) !== -32'sd7) begin
          errors++;
          $display("FAIL negative_w3 got %0d want -7", wk(k));
        end
      end else if (wk(k) !== 32'(k)) begin
        errors++;
        $display("FAIL negative_w%0d got %0d want %0d", k, wk(k), k);
      end
    end
  endtask

  task automatic test_saturation();
    logic [NT*XB-1:0] xv;
    // +2^19 per step, then two steps of 262143 land exactly on 2^31-2.
    for (int i = 0; i < 4095; i++) fast_step(32'sh80000000, 14'h2000);
    checks++;
    if (wk(0) !== 32'sd2146959360) begin
      errors++;
      $display("FAIL sat_preload_a got %0d want 2146959360", wk(0));
    end
    fast_step(32'sh7FFFFFFF, 14'd4096);
    fast_step(32'sh7FFFFFFF, 14'd4096);
    checks++;
    if (wk(0) !== 32'sd2147483646) begin
      errors++;
      $display("FAIL sat_preload_b got %0d want 2147483646", wk(0));
    end
    xv = '0;
    xv[XB-1:0] = 14'd8191;
    run_update(32'sh7FFFFFFF, xv);
    checks++;
    if (wk(0) !== 32'sh7FFFFFFF) begin
      errors++;
      $display("FAIL sat_pos_clamp got %0d want 2147483647", wk(0));
    end
    checks++;
    if (wk(3) !== -32'sd7) begin
      errors++;
      $display("FAIL sat_w3_untouched got %0d want -7", wk(3));
    end
    do_clr();
    // -524224 per step: 4096 steps stop just above the floor, one more clamps.
    for (int i = 0; i < 4096; i++) fast_step(32'sh80000000, 14'd8191);
    checks++;
    if (wk(0) !== -32'sd2147221504) begin
      errors++;
      $display("FAIL sat_neg_preload got %0d want -2147221504", wk(0));
    end
    fast_step(32'sh80000000, 14'd8191);
    checks++;
    if (wk(0) !== 32'sh80000000) begin
      errors++;
      $display("FAIL sat_neg_clamp got %0d want -2147483648", wk(0));
    end
  endtask

  task automatic test_abort();
    int done_cnt = 0;
    do_clr();
    e = 32'sd33554432;
    for (int k = 0; k < NT; k++) x[k*XB +: XB] = XB'(k + 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    e     = 32'sd67108864;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy_before got %b want 1", busy);
    end
    en = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy_after got %b want 0", busy);
    end
    for (int i = 0; i < NT + 4; i++) begin
      if (done) done_cnt++;
      tick();
    end
    en = 1'b1;
    checks++;
    if (done_cnt !== 0) begin
      errors++;
      $display("FAIL abort_no_done got %0d pulses want 0", done_cnt);
    end
    for (int k = 0; k < NT; k++) begin
      checks++;
      if (wk(k) !== ((k < 4) ? 32'(k + 1) : 32'sd0)) begin
        errors++;
        $display("FAIL abort_w%0d got %0d want %0d", k, wk(k), (k < 4) ? k + 1 : 0);
      end
    end
  endtask

  task automatic test_clr_start();
    en    = 1'b1;
    clr   = 1'b1;
    start = 1'b1;
    e     = 32'sd33554432;
    tick();
    clr   = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_start_busy got %b want 0", busy);
    end
    repeat (3) tick();
    checks++;
    if (weight_out !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_start_weights got %h busy=%b want 0 0", weight_out, busy);
    end
  endtask

  task automatic test_reset_mid_update();
    e = 32'sd33554432;
    for (int k = 0; k < NT; k++) x[k*XB +: XB] = XB'(k + 1);
    en    = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    checks++;
    if (wk(4) !== 32'sd5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre got w4=%0d busy=%b want 5 1", wk(4), busy);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (weight_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async got %h busy=%b done=%b want 0", weight_out, busy, done);
    end
    tick();
    rstn = 1'b1;
    repeat (NT + 2) tick();
    checks++;
    if (weight_out !== '0) begin
      errors++;
      $display("FAIL midreset_no_resume got %h want 0", weight_out);
    end
  endtask

  initial begin
    test_reset();
    test_single_update();
    test_negative_step();
    test_saturation();
    test_abort();
    test_clr_start();
    test_reset_mid_update();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lms_weight_update.md
Name: lms_weight_update

Overview:
- Weight-update engine for the 16-tap serial adaptive FIR: consumes the error sample e and the reference tap vector, and applies the LMS rule w[k] += (e * x[k]) >>> MU_SHIFT, one tap per clock.
- Owns the 16 coefficient registers and drives them back to the filter's weight inputs.
- Sits between the error output of the filter and its weight inputs, closing the adaptation loop; started by the controller once e is valid.

Parameters:
- NTAPS, 16, number of taps/coefficients.
- XW, 14, reference sample width (signed).
- WW, 32, weight and error width (signed).
- MU_SHIFT, 25, step size mu = 2^-MU_SHIFT, applied as an arithmetic right shift.

Ports:
- clk  in  1  clock, all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- en  in  1  adaptation enable; low aborts and holds.
- clr  in  1  synchronous clear of all weights to 0, honoured only in IDLE.
- start  in  1  one-cycle request: e and x are valid this cycle.
- e  in  WW  signed error sample.
- x  in  NTAPS*XW  packed signed reference taps, tap k at bits [k*XW +: XW].
- busy  out  1  high during UPDATE.
- done  out  1  one-cycle pulse after the last tap is written.
- weight_out  out  NTAPS*WW  packed signed weights, tap k at [k*WW +: WW].

Behaviour:
- Reset, driven asynchronously by rstn: all weights 0, state IDLE, busy 0, done 0, tap index 0, e/x snapshots 0.
- States: IDLE, UPDATE, DONE.
- IDLE:
  - If clr=1, all weights become 0 and start is ignored that cycle. clr has priority over start.
  - If en=1 and start=1, snapshot e and x, set index 0, go to UPDATE.
- UPDATE, each cycle with index k:
  - prod = e_snap * x_snap[k], signed 46 bits.
  - step = prod >>> MU_SHIFT, arithmetic shift, saturated to WW bits.
  - w[k] = sat_WW(w[k] + step).
  - Index increments; after k = NTAPS-1 go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Timing: start sampled at edge T. Tap k is written at edge T+1+k. done is high in the cycle after edge T+NTAPS. busy is high for exactly NTAPS cycles.
- Latency from start to done: NTAPS+1 cycles.
- Minimum start-to-start interval: NTAPS+2 cycles.
- start while busy or in DONE is ignored; it is not queued.
- Snapshot: e and x are not re-sampled during UPDATE, so changes on those inputs mid-update have no effect.
- en=0 in any state: next state IDLE, no further weight writes, done not pulsed. Already-written taps keep their new values (partial update accepted). clr still works in IDLE with en=0.
- Saturation: both step and sum clamp to [-2^(WW-1), 2^(WW-1)-1]. There is no wrap-around.
- weight_out is driven directly from the registers, so a write is visible the cycle after its edge.
- Reset asserted mid-update: immediate return to reset values.

Decomposition:
- Shared package adaptive_pkg:
  - NTAPS, XW, WW, MU_SHIFT defaults.
  - State enum {IDLE, UPDATE, DONE}.
  - Function sat_add(a, b, width).
  - Function sat_trunc(value, width).
- One sub-module, lms_tap_mac: combinational signed multiply, shift and saturate of e_snap * x_k, producing step. It is instantiated once and muxed by the tap index.
- The weight register file stays in the top module.

Test Plan:
- Reset then idle: weight_out all 0, busy=0, done=0. start with en=0 -> no change, busy stays 0.
- Single update: e = 2^25, x[k] = k for all k, start once -> w[k] = k. busy high 16 cycles, done pulses at T+17.
- Negative step: weights from the previous case, e = -2^26, x[3] = 5, other taps 0 -> w[3] = 3 - 10 = -7; all other weights unchanged.
- Saturation: w[0] = 2^31 - 2 preloaded by repeated updates, e = 2^31 - 1, x[0] = 8191 -> w[0] = 2^31 - 1. Negative mirror clamps to -2^31.
- Abort: en dropped at T+5 -> taps 0..3 updated, taps 4..15 unchanged, no done pulse. start re-issued while busy -> ignored.
- clr with start in the same cycle in IDLE -> all weights 0 and no UPDATE entered. Reset asserted mid-UPDATE -> weights 0 immediately.
